// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared codes, masks and floor helpers for the elevator car/door blocks
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_STOP   = 2'b00,
    DIR_DOWN   = 2'b01,
    DIR_UP     = 2'b10,
    DIR_UPDOWN = 2'b11
  } dir_t;

  localparam logic ON         = 1'b1;
  localparam logic OFF        = 1'b0;
  localparam logic DOOR_OPEN  = 1'b1;
  localparam logic DOOR_CLOSE = 1'b0;

  localparam logic [2:0] FLOOR_MIN = 3'd1;
  localparam logic [2:0] FLOOR_MAX = 3'd7;

  // Top floor has no up call, bottom floor has no down call.
  localparam logic [FLOOR_MAX:1] HALL_UP_MASK   = 7'b0111111;
  localparam logic [FLOOR_MAX:1] HALL_DOWN_MASK = 7'b1111110;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRAVEL  = 3'd1,
    ST_STOPCHK = 3'd2,
    ST_ARRIVE  = 3'd3,
    ST_OPEN    = 3'd4,
    ST_DECIDE  = 3'd5
  } state_t;

  // Bit of a floor-indexed vector; floor 0 reads as 0.
  function automatic logic bit_at(input logic [FLOOR_MAX:1] vec, input logic [2:0] f);
    logic [7:0] v;
    v = {vec, 1'b0};
    return v[f];
  endfunction

  // Any bit strictly above floor f.
  function automatic logic any_above(input logic [FLOOR_MAX:1] vec, input logic [2:0] f);
    logic [7:0] v;
    v = {vec, 1'b0};
    return (v >> ({1'b0, f} + 4'd1)) != 8'd0;
  endfunction

  // Any bit strictly below floor f (bit 0 is always zero).
  function automatic logic any_below(input logic [FLOOR_MAX:1] vec, input logic [2:0] f);
    logic [7:0] v;
    v = {vec, 1'b0};
    return (v & ((8'd1 << f) - 8'd1)) != 8'd0;
  endfunction

  // One-hot floor vector for floor f.
  function automatic logic [FLOOR_MAX:1] floor_onehot(input logic [2:0] f);
    logic [7:0] v;
    v = 8'd1 << f;
    return v[7:1];
  endfunction

endpackage

// File: rtl/ele_request_regs.sv
// rtl/ele_request_regs.sv - latched hall/car request vectors with clear-wins rule
module ele_request_regs import elevator_pkg::*; (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FLOOR_MAX:1]   i_hall_up,
  input  logic [FLOOR_MAX:1]   i_hall_down,
  input  logic [FLOOR_MAX:1]   i_car_call,
  input  logic [FLOOR_MAX:1]   i_clr_up,
  input  logic [FLOOR_MAX:1]   i_clr_down,
  input  logic [FLOOR_MAX:1]   i_clr_car,
  output logic [FLOOR_MAX:1]   o_up_pending,
  output logic [FLOOR_MAX:1]   o_down_pending,
  output logic [FLOOR_MAX:1]   o_car_pending
);

  logic [FLOOR_MAX:1] r_up;
  logic [FLOOR_MAX:1] r_down;
  logic [FLOOR_MAX:1] r_car;

  // Set on a press, clear on service; a press while being served is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_up   <= '0;
      r_down <= '0;
      r_car  <= '0;
    end else begin
      r_up   <= (r_up   | (i_hall_up   & HALL_UP_MASK))   & ~i_clr_up;
      r_down <= (r_down | (i_hall_down & HALL_DOWN_MASK)) & ~i_clr_down;
      r_car  <= (r_car  | i_car_call)                     & ~i_clr_car;
    end
  end

  assign o_up_pending   = r_up;
  assign o_down_pending = r_down;
  assign o_car_pending  = r_car;

endmodule

// File: rtl/car_motion_ctrl.sv
// rtl/car_motion_ctrl.sv - car scan FSM, travel timer and request latching for a 7-floor elevator
module car_motion_ctrl import elevator_pkg::*; #(
  parameter int NUM_FLOORS    = 7,
  parameter int CLK_PER_FLOOR = 1000000000,
  parameter int OPEN_WAIT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS:1]   hallUp,
  input  logic [NUM_FLOORS:1]   hallDown,
  input  logic [NUM_FLOORS:1]   carCall,
  input  logic                  doorState,
  output logic [2:0]            currentFloor,
  output logic [1:0]            currentDirection,
  output logic [1:0]            currentFloorButton,
  output logic                  moving,
  output logic [NUM_FLOORS:1]   upPending,
  output logic [NUM_FLOORS:1]   downPending,
  output logic [NUM_FLOORS:1]   carPending
);

  localparam int CW = (CLK_PER_FLOOR > 1) ? $clog2(CLK_PER_FLOOR) : 1;
  localparam int WW = (OPEN_WAIT > 1) ? $clog2(OPEN_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_PER_FLOOR - 1);
  localparam logic [WW-1:0] WAIT_END = WW'(OPEN_WAIT - 1);

  state_t        r_state, w_state_nxt;
  dir_t          r_dir, w_dir_nxt;
  logic [2:0]    r_floor, w_floor_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [WW-1:0] r_wait, w_wait_nxt;

  logic [NUM_FLOORS:1] w_up_pend, w_dn_pend, w_car_pend, w_all_pend;
  logic [NUM_FLOORS:1] w_clr_up, w_clr_dn, w_clr_car;
  logic w_up_ahead, w_dn_ahead, w_here, w_up_here, w_dn_here, w_car_here;
  logic w_interlock;

  ele_request_regs u_req (
    .clk            (clk),
    .reset          (reset),
    .i_hall_up      (hallUp),
    .i_hall_down    (hallDown),
    .i_car_call     (carCall),
    .i_clr_up       (w_clr_up),
    .i_clr_down     (w_clr_dn),
    .i_clr_car      (w_clr_car),
    .o_up_pending   (w_up_pend),
    .o_down_pending (w_dn_pend),
    .o_car_pending  (w_car_pend)
  );

  assign w_all_pend  = w_up_pend | w_dn_pend | w_car_pend;
  assign w_up_ahead  = any_above(w_all_pend, r_floor);
  assign w_dn_ahead  = any_below(w_all_pend, r_floor);
  assign w_up_here   = bit_at(w_up_pend, r_floor);
  assign w_dn_here   = bit_at(w_dn_pend, r_floor);
  assign w_car_here  = bit_at(w_car_pend, r_floor);
  assign w_here      = w_up_here | w_dn_here | w_car_here;
  // An open door outside the stop states freezes the car completely.
  assign w_interlock = (doorState == DOOR_OPEN) && (r_state != ST_ARRIVE) && (r_state != ST_OPEN);

  // State, position, direction and timers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_STOP;
      r_floor <= FLOOR_MIN;
      r_cnt   <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_floor <= w_floor_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Scan decisions, travel stepping and request clears.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_floor_nxt = r_floor;
    w_cnt_nxt   = r_cnt;
    w_wait_nxt  = '0;
    w_clr_up    = '0;
    w_clr_dn    = '0;
    w_clr_car   = '0;

    if (r_state == ST_OPEN) begin
      w_clr_car = floor_onehot(r_floor);
      if (r_dir == DIR_UP)   w_clr_up = floor_onehot(r_floor);
      if (r_dir == DIR_DOWN) w_clr_dn = floor_onehot(r_floor);
    end

    if (!w_interlock) begin
      case (r_state)
        ST_IDLE: begin
          if (w_here) begin
            w_dir_nxt   = (w_up_here || w_car_here) ? DIR_UP : DIR_DOWN;
            w_state_nxt = ST_ARRIVE;
          end else if (w_up_ahead) begin
            w_dir_nxt   = DIR_UP;
            w_state_nxt = ST_TRAVEL;
            w_cnt_nxt   = CNT_LOAD;
          end else if (w_dn_ahead) begin
            w_dir_nxt   = DIR_DOWN;
            w_state_nxt = ST_TRAVEL;
            w_cnt_nxt   = CNT_LOAD;
          end
        end

        ST_TRAVEL: begin
          if (r_cnt == '0) begin
            if (r_dir == DIR_UP && r_floor != FLOOR_MAX)   w_floor_nxt = r_floor + 3'd1;
            if (r_dir == DIR_DOWN && r_floor != FLOOR_MIN) w_floor_nxt = r_floor - 3'd1;
            w_state_nxt = ST_STOPCHK;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end

        ST_STOPCHK: begin
          if (r_dir == DIR_DOWN) begin
            if (w_car_here || w_dn_here) begin
              w_state_nxt = ST_ARRIVE;
            end else if (w_up_here && !w_dn_ahead) begin
              w_dir_nxt   = DIR_UP;
              w_state_nxt = ST_ARRIVE;
            end else if (w_dn_ahead) begin
              w_state_nxt = ST_TRAVEL;
              w_cnt_nxt   = CNT_LOAD;
            end else begin
              w_state_nxt = ST_DECIDE;
            end
          end else begin
            if (w_car_here || w_up_here) begin
              w_state_nxt = ST_ARRIVE;
            end else if (w_dn_here && !w_up_ahead) begin
              w_dir_nxt   = DIR_DOWN;
              w_state_nxt = ST_ARRIVE;
            end else if (w_up_ahead) begin
              w_state_nxt = ST_TRAVEL;
              w_cnt_nxt   = CNT_LOAD;
            end else begin
              w_state_nxt = ST_DECIDE;
            end
          end
        end

        ST_ARRIVE: begin
          if (doorState == DOOR_OPEN) begin
            w_state_nxt = ST_OPEN;
          end else if (r_wait == WAIT_END) begin
            w_state_nxt = ST_DECIDE;
          end else begin
            w_wait_nxt = r_wait + 1'b1;
          end
        end

        ST_OPEN: begin
          if (doorState == DOOR_CLOSE) w_state_nxt = ST_DECIDE;
        end

        ST_DECIDE: begin
          if (r_dir == DIR_DOWN && w_dn_ahead) begin
            w_state_nxt = ST_TRAVEL;
            w_cnt_nxt   = CNT_LOAD;
          end else if (r_dir != DIR_DOWN && w_up_ahead) begin
            w_dir_nxt   = DIR_UP;
            w_state_nxt = ST_TRAVEL;
            w_cnt_nxt   = CNT_LOAD;
          end else if (r_dir == DIR_DOWN && w_up_ahead) begin
            w_dir_nxt   = DIR_UP;
            w_state_nxt = ST_TRAVEL;
            w_cnt_nxt   = CNT_LOAD;
          end else if (r_dir != DIR_DOWN && w_dn_ahead) begin
            w_dir_nxt   = DIR_DOWN;
            w_state_nxt = ST_TRAVEL;
            w_cnt_nxt   = CNT_LOAD;
          end else if (w_here) begin
            // Re-aim at the waiting call so the door can match it.
            w_dir_nxt   = (w_up_here || w_car_here) ? DIR_UP : DIR_DOWN;
            w_state_nxt = ST_ARRIVE;
          end else begin
            w_dir_nxt   = DIR_STOP;
            w_state_nxt = ST_IDLE;
          end
        end

        default: begin
          w_dir_nxt   = DIR_STOP;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign currentFloor       = r_floor;
  assign currentDirection   = r_dir;
  assign moving             = (r_state == ST_TRAVEL) ? ON : OFF;
  assign currentFloorButton = {w_up_here, w_dn_here};
  assign upPending          = w_up_pend;
  assign downPending        = w_dn_pend;
  assign carPending         = w_car_pend;

endmodule

// File: doc/car_motion_ctrl.md
Name: car_motion_ctrl

Overview:
Car-side counterpart of the door controller. Latches hall and car calls, runs the 7-floor two-way scan, and moves the car one floor per CLK_PER_FLOOR cycles. It drives the currentFloor, currentDirection, currentFloorButton and moving signals that the door block consumes, and holds the car while doorState is OPEN. moving drives the door block's reset, so the door is forced CLOSE while travelling.

Parameters:
NUM_FLOORS, 7, floors numbered 1..NUM_FLOORS; fixed at 7 by the 3-bit floor encoding
CLK_PER_FLOOR, 1000000000, clk cycles of travel per floor
OPEN_WAIT, 2, cycles to wait in ARRIVE for doorState to rise before skipping the stop

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
hallUp  in  [7:1]  up hall-button pulses; bit 7 ignored
hallDown  in  [7:1]  down hall-button pulses; bit 1 ignored
carCall  in  [7:1]  in-car floor-button pulses
doorState  in  1  1 = OPEN, 0 = CLOSE (from door block)
currentFloor  out  3  current floor, 1..7
currentDirection  out  2  STOP=00, UP=10, DOWN=01; UPDOWN=11 is never driven
currentFloorButton  out  2  {upPending[currentFloor], downPending[currentFloor]}, combinational
moving  out  1  1 while travelling between floors
upPending, downPending, carPending  out  [7:1] each  latched requests, for lamps and the door's internalButton

Behaviour:
- Reset (reset=0, async): currentFloor=1, currentDirection=STOP, moving=0, all pending=0, travel counter=0, state=IDLE.
- Request latch: an input pulse sets its pending bit the next cycle; hallUp[7] and hallDown[1] are never latched.
- Clear happens in state OPEN at currentFloor: carPending always; upPending if direction UP; downPending if direction DOWN.
- Set and clear of the same bit in the same cycle: clear wins. A press while the door is open is treated as served.
- "ahead(dir)": any pending bit at a floor strictly above (UP) or below (DOWN) currentFloor.
- IDLE (direction STOP, moving=0):
  - request at currentFloor: set direction UP if upPending or carPending there, else DOWN; go to ARRIVE.
  - else ahead(UP): direction UP, go to TRAVEL.
  - else ahead(DOWN): direction DOWN, go to TRAVEL.
  - else stay in IDLE.
  - UP is checked before DOWN in every tie.
- TRAVEL: moving=1, counter loads CLK_PER_FLOOR-1 and decrements. At 0, currentFloor steps ±1, moving drops the same cycle, go to STOPCHK.
- STOPCHK (1 cycle), heading UP at floor f: stop if carPending[f], upPending[f], or (downPending[f] and !ahead(UP)). DOWN is symmetric.
  - On a stop where the only match is a reverse-direction hall call, currentDirection flips before ARRIVE so the door's direction match succeeds.
  - stop: go to ARRIVE.
  - no stop and ahead(dir): go to TRAVEL.
  - no stop and nothing ahead: go to DECIDE.
- ARRIVE: wait up to OPEN_WAIT cycles for doorState=1, then go to OPEN. On timeout go to DECIDE; this is a skipped stop, not an error.
- OPEN: the car holds while doorState=1, with moving=0 and currentFloor/currentDirection stable; clears are applied here. doorState=0 goes to DECIDE.
- DECIDE (1 cycle):
  - ahead(current dir): keep direction, go to TRAVEL.
  - else ahead(opposite): reverse, go to TRAVEL.
  - else request at currentFloor: go to ARRIVE.
  - else direction=STOP, go to IDLE.
- Boundaries: currentFloor never leaves 1..7. At floor 7 ahead(UP)=0; at floor 1 ahead(DOWN)=0.
- doorState=1 in any state other than ARRIVE/OPEN: counter freezes, moving is held, no floor step occurs. This is an interlock; a well-behaved door cannot cause it.
- Reset mid-travel returns the car to floor 1 immediately (no homing run).

Decomposition:
- Shared package elevator_pkg:
  - direction codes STOP/UP/DOWN/UPDOWN
  - ON/OFF, OPEN/CLOSE
  - FLOOR_MIN=1, FLOOR_MAX=7
  - state encoding IDLE/TRAVEL/STOPCHK/ARRIVE/OPEN/DECIDE
- One sub-module, ele_request_regs: the three pending vectors with set/clear ports, the ignore masks and the clear-wins rule. The scan FSM and travel counter stay in car_motion_ctrl.

Test Plan:
All scenarios use CLK_PER_FLOOR=4 and a door model that opens 1 cycle after a direction match, stays open 5 cycles, then closes.
1. Reset at floor 1, carCall[4] pulse -> direction=UP; moving=1 for 3 floors (12 travel cycles plus STOPCHKs); stop at 4; carPending[4] cleared during OPEN; DECIDE -> IDLE with direction STOP.
2. From floor 1, hallDown[5] and hallUp[3] -> stops at 3 (up call), continues and stops at 5 with currentDirection flipped to DOWN, currentFloorButton=01 there.
3. At floor 3 in OPEN, carCall[3] pressed while doorState=1 -> carPending[3] stays 0 (clear wins); no re-open after close.
4. hallUp[7] and hallDown[1] pulses at reset state -> nothing latched; remains IDLE at floor 1 with direction STOP.
5. Travelling UP from 2, assert doorState=1 mid-counter -> counter frozen, floor unchanged, moving=1; release -> travel resumes with the remaining count.
6. Assert reset=0 while moving between floors 5 and 6 -> same-cycle async clear: floor=1, direction=STOP, moving=0, all pending=0.
